// File: rtl/spi_tx_fifo_pkg.sv
// Shared types and constants for the SPI transmit FIFO.
// Status struct carries FIFO flags into the SPI status register.
package spi_tx_fifo_pkg;

  localparam int TFIFO_DATA_WIDTH = 32;
  localparam int TFIFO_DEPTH      = 16;
  localparam int TFIFO_AW         = $clog2(TFIFO_DEPTH);

  typedef struct packed {
    logic                full;
    logic                empty;
    logic                thresh_hit;
    logic                ovf;
    logic [TFIFO_AW:0]   level;
  } tfifo_status_t;

  function automatic tfifo_status_t tfifo_pack_status(
    input logic              full,
    input logic              empty,
    input logic              thresh_hit,
    input logic              ovf,
    input logic [TFIFO_AW:0] level
  );
    tfifo_status_t s;
    s.full       = full;
    s.empty      = empty;
    s.thresh_hit = thresh_hit;
    s.ovf        = ovf;
    s.level      = level;
    return s;
  endfunction

endpackage

// File: rtl/spi_tx_fifo_if.sv
// Push/pop/status bundle between APB slave, TX FIFO and shift engine.
// Underrun signals exist only when SPI_TX_FIFO_UNDERRUN_EN is defined.
interface spi_tx_fifo_if
  import spi_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TFIFO_DATA_WIDTH,
  parameter int DEPTH      = TFIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  flush;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic [AW:0]           level;
  logic [AW:0]           thresh;
  logic                  thresh_hit;
  logic                  ovf;
  logic                  ovf_clr;
`ifdef SPI_TX_FIFO_UNDERRUN_EN
  logic                  udr;
  logic                  udr_clr;
`endif

  modport master (
    output wr_en, wr_data, flush, rd_ready, thresh, ovf_clr,
`ifdef SPI_TX_FIFO_UNDERRUN_EN
    output udr_clr,
    input  udr,
`endif
    input  rd_valid, rd_data, full, empty, level, thresh_hit, ovf
  );

  modport slave (
    input  wr_en, wr_data, flush, rd_ready, thresh, ovf_clr,
`ifdef SPI_TX_FIFO_UNDERRUN_EN
    input  udr_clr,
    output udr,
`endif
    output rd_valid, rd_data, full, empty, level, thresh_hit, ovf
  );

endinterface

// File: rtl/spi_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: synchronous write, asynchronous read.
// Contents are intentionally not reset; shared by the TX and RX FIFOs.
module spi_fifo_mem #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spi_tx_fifo.sv
// SPI transmit FIFO: first-word-fall-through, wrap-bit pointers, sticky overflow.
// Optional sticky underrun flag enabled by defining SPI_TX_FIFO_UNDERRUN_EN.
module spi_tx_fifo
  import spi_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = TFIFO_DATA_WIDTH,
  parameter int DEPTH      = TFIFO_DEPTH
) (
  input  logic          pclk,
  input  logic          preset_n,
  spi_tx_fifo_if.slave  fifo_if
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        pop_req;
  logic        pop;
  logic        push;
  logic        ovf_set;
  logic        ovf_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign pop_req = !empty && fifo_if.rd_ready;
  assign pop     = pop_req && !fifo_if.flush;
  assign push    = fifo_if.wr_en && !fifo_if.flush && (!full || pop_req);
  assign ovf_set = fifo_if.wr_en && !fifo_if.flush && full && !pop_req;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (fifo_if.flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Set has priority over clear so a colliding overflow is never lost
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (fifo_if.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef SPI_TX_FIFO_UNDERRUN_EN
  logic udr_set;
  logic udr_q;

  assign udr_set = fifo_if.rd_ready && empty && !fifo_if.flush;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      udr_q <= 1'b0;
    end else if (udr_set) begin
      udr_q <= 1'b1;
    end else if (fifo_if.udr_clr) begin
      udr_q <= 1'b0;
    end
  end

  assign fifo_if.udr = udr_q;
`endif

  spi_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (pclk),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (fifo_if.wr_data),
    .raddr (rptr[AW-1:0]),
    .rdata (fifo_if.rd_data)
  );

  assign fifo_if.rd_valid   = !empty;
  assign fifo_if.full       = full;
  assign fifo_if.empty      = empty;
  assign fifo_if.level      = level;
  assign fifo_if.thresh_hit = (level <= fifo_if.thresh);
  assign fifo_if.ovf        = ovf_q;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: queue-based reference model plus directed literals.
// Checks udr as well when SPI_TX_FIFO_UNDERRUN_EN is defined.
module tb_spi_tx_fifo;
  import spi_tx_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic pclk     = 1'b0;
  logic preset_n = 1'b0;
  bit   clk_run  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_udr = 1'b0;

  spi_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifo_if ();

  spi_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .fifo_if  (fifo_if.slave)
  );

  initial begin
    forever begin
      #5;
      if (clk_run) pclk = ~pclk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary forced");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    chk("empty",      DW'(fifo_if.empty),      DW'(sz == 0));
    chk("full",       DW'(fifo_if.full),       DW'(sz == DEPTH));
    chk("level",      DW'(fifo_if.level),      DW'(sz));
    chk("rd_valid",   DW'(fifo_if.rd_valid),   DW'(sz != 0));
    chk("thresh_hit", DW'(fifo_if.thresh_hit), DW'(sz <= int'(fifo_if.thresh)));
    chk("ovf",        DW'(fifo_if.ovf),        DW'(m_ovf));
`ifdef SPI_TX_FIFO_UNDERRUN_EN
    chk("udr",        DW'(fifo_if.udr),        DW'(m_udr));
`endif
    if (sz > 0) chk("rd_data", fifo_if.rd_data, q[0]);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare at the falling edge
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit rr,
                     input bit fl = 1'b0, input bit oc = 1'b0, input bit uc = 1'b0);
    bit pop_m, push_m, ovs, uds;
    fifo_if.wr_en    = w;
    fifo_if.wr_data  = d;
    fifo_if.rd_ready = rr;
    fifo_if.flush    = fl;
    fifo_if.ovf_clr  = oc;
`ifdef SPI_TX_FIFO_UNDERRUN_EN
    fifo_if.udr_clr  = uc;
`endif
    @(posedge pclk);
    ovs = 1'b0;
    uds = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      pop_m  = rr && (q.size() > 0);
      push_m = w && ((q.size() < DEPTH) || pop_m);
      ovs    = w && (q.size() == DEPTH) && !pop_m;
      uds    = rr && (q.size() == 0);
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(d);
    end
    if (ovs)     m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    if (uds)     m_udr = 1'b1;
    else if (uc) m_udr = 1'b0;
    @(negedge pclk);
    compare_all();
  endtask

  initial begin
    int wp, rp;
    fifo_if.wr_en    = 1'b0;
    fifo_if.wr_data  = '0;
    fifo_if.rd_ready = 1'b0;
    fifo_if.flush    = 1'b0;
    fifo_if.ovf_clr  = 1'b0;
    fifo_if.thresh   = '0;
`ifdef SPI_TX_FIFO_UNDERRUN_EN
    fifo_if.udr_clr  = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_empty",      DW'(fifo_if.empty),      1);
    chk("rst_full",       DW'(fifo_if.full),       0);
    chk("rst_level",      DW'(fifo_if.level),      0);
    chk("rst_rd_valid",   DW'(fifo_if.rd_valid),   0);
    chk("rst_thresh_hit", DW'(fifo_if.thresh_hit), 1);
    chk("rst_ovf",        DW'(fifo_if.ovf),        0);
    preset_n = 1'b1;
    cyc(0, '0, 0);

`ifdef SPI_TX_FIFO_UNDERRUN_EN
    cyc(0, '0, 1);
    chk("udr_set", DW'(fifo_if.udr), 1);
    cyc(0, '0, 0, 0, 0, 1);
    chk("udr_clr", DW'(fifo_if.udr), 0);
`endif

    // Two pushes, then one pop
    cyc(1, 32'h18, 0);
    cyc(1, 32'hA5, 0);
    chk("t2_level", DW'(fifo_if.level), 2);
    chk("t2_head",  fifo_if.rd_data, 32'h18);
    cyc(0, '0, 1);
    chk("t2_head_after_pop", fifo_if.rd_data, 32'hA5);
    chk("t2_level_after_pop", DW'(fifo_if.level), 1);
    cyc(0, '0, 1);
    chk("t2_empty", DW'(fifo_if.empty), 1);

    // Fill, overflow, drain, clear overflow
    for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0);
    chk("t3_full",  DW'(fifo_if.full), 1);
    chk("t3_level", DW'(fifo_if.level), 16);
    cyc(1, 32'hDEAD, 0);
    chk("t3_ovf",       DW'(fifo_if.ovf), 1);
    chk("t3_level_ovf", DW'(fifo_if.level), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop_data", fifo_if.rd_data, DW'(i));
      cyc(0, '0, 1);
    end
    chk("t3_drained", DW'(fifo_if.empty), 1);
    cyc(0, '0, 0, 0, 1);
    chk("t3_ovf_clr", DW'(fifo_if.ovf), 0);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0);
    chk("t4_head", fifo_if.rd_data, 32'h0);
    cyc(1, 32'h55, 1);
    chk("t4_level", DW'(fifo_if.level), 16);
    chk("t4_ovf",   DW'(fifo_if.ovf), 0);
    for (int i = 1; i < 16; i++) begin
      chk("t4_pop_data", fifo_if.rd_data, DW'(i));
      cyc(0, '0, 1);
    end
    chk("t4_sixteenth", fifo_if.rd_data, 32'h55);
    cyc(0, '0, 1);
    chk("t4_empty", DW'(fifo_if.empty), 1);

    // Threshold boundary, then streaming across the pointer wrap
    fifo_if.thresh = 5'd4;
    cyc(0, '0, 0);
    for (int k = 0; k <= 5; k++) begin
      chk("t5_thresh_hit", DW'(fifo_if.thresh_hit), (k <= 4) ? 1 : 0);
      cyc(1, DW'(32'h200 + k), 0);
    end
    for (int j = 0; j < 40; j++) cyc(1, DW'(32'h100 + j), 1);
    chk("t5_level_stream", DW'(fifo_if.level), 6);
    for (int j = 0; j < 40 && q.size() > 0; j++) cyc(0, '0, 1);
    chk("t5_drained", DW'(fifo_if.empty), 1);

    // Flush with a concurrent push, ovf left set
    for (int i = 0; i < 17; i++) cyc(1, DW'(32'h300 + i), 0);
    for (int i = 0; i < 9; i++)  cyc(0, '0, 1);
    chk("t6_level7", DW'(fifo_if.level), 7);
    cyc(1, 32'hBEEF, 0, 1);
    chk("t6_flush_level", DW'(fifo_if.level), 0);
    chk("t6_flush_empty", DW'(fifo_if.empty), 1);
    chk("t6_flush_ovf",   DW'(fifo_if.ovf), 1);

    // Asynchronous reset with the clock stopped
    for (int i = 0; i < 5; i++) cyc(1, DW'(32'h400 + i), 0);
    fifo_if.wr_en = 1'b0;
    clk_run = 1'b0;
    #2;
    preset_n = 1'b0;
    #1;
    chk("t7_empty",      DW'(fifo_if.empty),      1);
    chk("t7_full",       DW'(fifo_if.full),       0);
    chk("t7_level",      DW'(fifo_if.level),      0);
    chk("t7_rd_valid",   DW'(fifo_if.rd_valid),   0);
    chk("t7_thresh_hit", DW'(fifo_if.thresh_hit), 1);
    chk("t7_ovf",        DW'(fifo_if.ovf),        0);
    q.delete();
    m_ovf = 1'b0;
    m_udr = 1'b0;
    #3;
    preset_n = 1'b1;
    clk_run  = 1'b1;
    cyc(0, '0, 0);

    // Randomised traffic with shifting push/pop bias
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        wp = $urandom_range(10, 95);
        rp = $urandom_range(10, 95);
      end
      if ($urandom_range(0, 31) == 0) fifo_if.thresh = 5'($urandom_range(0, DEPTH));
      cyc($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
          $urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
